// File: rtl/vram_pkg.sv
// Shared types for the host-side VRAM writer: op codes, mode word layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vram_pkg;

  // Default VRAM address width (8 KiB).
  localparam int VRAM_ADDR_W = 13;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_FILL  = 2'b01,
    OP_MODE  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Field order matches the host mode word {css, gm[2:0], ag} in bits [4:0].
  typedef struct packed {
    logic       css;
    logic [2:0] gm;
    logic       ag;
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO queuing pending byte writes ({addr, data} entries).
// Latency: pushed entry is visible at head the cycle after the push.
// Backpressure: full blocks further pushes; pop when empty is ignored.
//
// Ports: clk/rst (async active-high, resets to empty); push/push_dat;
// pop/head_dat (head is combinational from storage); full, empty, count.
module vram_wr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 21,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/vram_write_ctrl.sv
// Host-side VRAM writer: byte writes via FIFO, block fills, frame-synchronous mode registers.
// Latency: write strobe is registered, earliest the cycle after accept, only after a free fetch slot.
// Backpressure: write stalls on full FIFO; fill stalls unless idle and FIFO empty; mode/reserved never stall.
//
// Ports: pixel_clock, reset (async active-high); host_valid/host_ready/host_op/
// host_addr/host_data/host_len command channel; fetch_phase, frame_start from display;
// vram_we/vram_waddr/vram_wdata write port; ag/gm/css active mode; busy status.
module vram_write_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [1:0]        host_op,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  input  logic [ADDR_W-1:0] host_len,
  input  logic [3:0]        fetch_phase,
  input  logic              frame_start,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [7:0]        vram_wdata,
  output logic              ag,
  output logic [2:0]        gm,
  output logic              css,
  output logic              busy
);

  localparam int EW = ADDR_W + 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d;
  logic [ADDR_W-1:0] f_cnt_q, f_cnt_d;
  logic [7:0]        f_data_q, f_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  mode_t             pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  mode_t             mode_q, mode_d;
  logic              busy_q, busy_d;

  logic              slot_ok;
  logic              acc, acc_wr, acc_fill, acc_mode;
  logic              bypass;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_cnt, fifo_cnt_nxt;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_data;

  // Phases 1..3 are when the display owns the VRAM port.
  assign slot_ok = !(fetch_phase inside {4'd1, 4'd2, 4'd3});

  always_comb begin
    host_ready = 1'b1;
    case (op_e'(host_op))
      OP_WRITE: host_ready = ~fifo_full;
      // Fill only starts once every earlier byte has been committed.
      OP_FILL:  host_ready = (state_q == S_IDLE) && fifo_empty;
      default:  host_ready = 1'b1;
    endcase
  end

  assign acc      = host_valid & host_ready;
  assign acc_wr   = acc && (op_e'(host_op) == OP_WRITE);
  assign acc_fill = acc && (op_e'(host_op) == OP_FILL);
  assign acc_mode = acc && (op_e'(host_op) == OP_MODE);

  assign {head_addr, head_data} = fifo_head;

  // A write arriving to an idle, empty queue during a free slot goes straight
  // to the VRAM registers so it lands the next cycle; ordering is preserved
  // because nothing older can be waiting.
  assign bypass    = (state_q == S_IDLE) && fifo_empty && slot_ok && acc_wr;
  assign fifo_push = acc_wr && !bypass;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (pixel_clock),
    .rst      (reset),
    .push     (fifo_push),
    .push_dat ({host_addr, host_data}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    f_addr_d = f_addr_q;
    f_cnt_d  = f_cnt_q;
    f_data_d = f_data_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    fifo_pop = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc_fill) begin
          f_addr_d = host_addr;
          f_cnt_d  = host_len;
          f_data_d = host_data;
          state_d  = S_FILL;
        end else if (slot_ok && !fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = 1'b1;
          waddr_d  = head_addr;
          wdata_d  = head_data;
        end else if (bypass) begin
          we_d     = 1'b1;
          waddr_d  = host_addr;
          wdata_d  = host_data;
        end
      end
      S_FILL: begin
        // The queue is deliberately left alone here; bytes accepted during
        // the fill must land after it.
        if (f_cnt_q == '0) begin
          state_d = S_IDLE;
        end else if (slot_ok) begin
          we_d     = 1'b1;
          waddr_d  = f_addr_q;
          wdata_d  = f_data_q;
          f_addr_d = f_addr_q + ADDR_W'(1);
          f_cnt_d  = f_cnt_q - ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending mode is consumed at frame start; a set-mode in the same cycle
  // becomes the next pending value rather than being applied now.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mode_d     = mode_q;
    if (frame_start && pend_vld_q) begin
      mode_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (acc_mode) begin
      pend_d     = mode_t'(host_data[4:0]);
      pend_vld_d = 1'b1;
    end
  end

  // busy includes the strobe being launched so it drops the cycle after it.
  assign fifo_cnt_nxt = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
  assign busy_d       = (state_d != S_IDLE) || (fifo_cnt_nxt != '0) || we_d;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      f_addr_q   <= '0;
      f_cnt_q    <= '0;
      f_data_q   <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mode_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_addr_q   <= f_addr_d;
      f_cnt_q    <= f_cnt_d;
      f_data_q   <= f_data_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
    end
  end

  assign vram_we    = we_q;
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign ag         = mode_q.ag;
  assign gm         = mode_q.gm;
  assign css        = mode_q.css;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Directed self-checking bench for vram_write_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_vram_write_ctrl;

  logic        pixel_clock;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_op;
  logic [12:0] host_addr;
  logic [7:0]  host_data;
  logic [12:0] host_len;
  logic [3:0]  fetch_phase;
  logic        frame_start;
  logic        vram_we;
  logic [12:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        ag;
  logic [2:0]  gm;
  logic        css;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int phase_bad = 0;
  logic        phase_run = 1'b0;
  logic [3:0]  ph_prev = 4'd0;
  logic [12:0] la_q [$];
  logic [7:0]  ld_q [$];

  localparam logic [1:0] WR = 2'b00, FL = 2'b01, MD = 2'b10;

  vram_write_ctrl dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_op     (host_op),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .host_len    (host_len),
    .fetch_phase (fetch_phase),
    .frame_start (frame_start),
    .vram_we     (vram_we),
    .vram_waddr  (vram_waddr),
    .vram_wdata  (vram_wdata),
    .ag          (ag),
    .gm          (gm),
    .css         (css),
    .busy        (busy)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  // Log every VRAM write; a strobe seen now was decided in the previous
  // cycle, so it must follow a free phase.
  always @(negedge pixel_clock) begin
    if (vram_we) begin
      la_q.push_back(vram_waddr);
      ld_q.push_back(vram_wdata);
      if (ph_prev inside {4'd1, 4'd2, 4'd3}) phase_bad++;
    end
    ph_prev = fetch_phase;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; optionally free-run the phase.
  task automatic cyc();
    @(posedge pixel_clock);
    #1;
    if (phase_run) fetch_phase = fetch_phase + 4'd1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [12:0] a, input logic [7:0] d,
                     input logic [12:0] len);
    host_valid = 1'b1;
    host_op    = op;
    host_addr  = a;
    host_data  = d;
    host_len   = len;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_op = WR; host_addr = '0; host_data = '0;
    host_len = '0; fetch_phase = 4'd5; frame_start = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_we",    32'(vram_we), 0);
    chk("rst_waddr", 32'(vram_waddr), 0);
    chk("rst_wdata", 32'(vram_wdata), 0);
    chk("rst_ag",    32'(ag), 0);
    chk("rst_gm",    32'(gm), 0);
    chk("rst_css",   32'(css), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ready", 32'(host_ready), 1);
    reset = 1'b0;

    // Two byte writes at free phase 5: each lands the cycle after accept
    cyc();
    cmd(WR, 13'h0100, 8'h12, 13'd0); #1;
    chk("wr1_ready", 32'(host_ready), 1);
    cyc();
    chk("wr1_we", 32'(vram_we), 1);
    chk("wr1_addr", 32'(vram_waddr), 'h100);
    chk("wr1_data", 32'(vram_wdata), 'h12);
    chk("wr1_busy", 32'(busy), 1);
    cmd(WR, 13'h0101, 8'h34, 13'd0);
    cyc();
    chk("wr2_we", 32'(vram_we), 1);
    chk("wr2_addr", 32'(vram_waddr), 'h101);
    chk("wr2_data", 32'(vram_wdata), 'h34);
    host_valid = 1'b0;
    cyc();
    chk("wr2_done_we", 32'(vram_we), 0);
    chk("wr2_busy_fall", 32'(busy), 0);

    // Phase 0 is a free slot: write goes through next cycle.
    // A write accepted at phase 1 waits for the slot decided at phase 4.
    cyc();
    fetch_phase = 4'd0;
    cmd(WR, 13'h0200, 8'h56, 13'd0);
    cyc();
    chk("ph0_we", 32'(vram_we), 1);
    chk("ph0_addr", 32'(vram_waddr), 'h200);
    fetch_phase = 4'd1;
    cmd(WR, 13'h0201, 8'h78, 13'd0);
    cyc();
    host_valid = 1'b0;
    chk("blk_ph1", 32'(vram_we), 0);
    fetch_phase = 4'd2;
    cyc();
    chk("blk_ph2", 32'(vram_we), 0);
    fetch_phase = 4'd3;
    cyc();
    chk("blk_ph3", 32'(vram_we), 0);
    fetch_phase = 4'd4;
    cyc();
    chk("blk_we", 32'(vram_we), 1);
    chk("blk_addr", 32'(vram_waddr), 'h201);
    chk("blk_data", 32'(vram_wdata), 'h78);
    fetch_phase = 4'd5;
    cyc();
    chk("blk_once", 32'(vram_we), 0);

    // Fill wrapping past the top of VRAM, free-running phases
    phase_run = 1'b1;
    cyc();
    la_q.delete(); ld_q.delete();
    cmd(FL, 13'h1FFE, 8'hAA, 13'd4); #1;
    chk("fw_ready", 32'(host_ready), 1);
    cyc();
    host_valid = 1'b0;
    wait_idle("fw_idle");
    chk("fw_count", 32'(la_q.size()), 4);
    if (la_q.size() == 4) begin
      chk("fw_a0", 32'(la_q[0]), 'h1FFE);
      chk("fw_a1", 32'(la_q[1]), 'h1FFF);
      chk("fw_a2", 32'(la_q[2]), 'h0000);
      chk("fw_a3", 32'(la_q[3]), 'h0001);
      for (int i = 0; i < 4; i++) chk("fw_data", 32'(ld_q[i]), 'hAA);
    end
    host_op = FL; #1;
    chk("fw_fill_ready_again", 32'(host_ready), 1);

    // Back-pressure and ordering: 5 writes during a 20-byte fill
    cyc();
    la_q.delete(); ld_q.delete();
    cmd(FL, 13'h0400, 8'h5A, 13'd20); #1;
    chk("bp_fill_ready", 32'(host_ready), 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      cmd(WR, 13'h0500 + 13'(i), 8'hC0 + 8'(i), 13'd0); #1;
      chk("bp_wr_ready", 32'(host_ready), 1);
    end
    cyc();
    cmd(FL, 13'h0000, 8'h00, 13'd1); #1;
    chk("bp_fill2_blocked", 32'(host_ready), 0);
    cmd(WR, 13'h0504, 8'hC4, 13'd0); #1;
    chk("bp_full", 32'(host_ready), 0);
    begin
      int n = 0;
      while (!host_ready && n < 80) begin
        cyc();
        n++;
      end
    end
    chk("bp_ready_rise", 32'(host_ready), 1);
    chk("bp_fill_done_first", 32'(la_q.size()), 20);
    cyc();
    host_valid = 1'b0;
    wait_idle("bp_idle");
    chk("bp_count", 32'(la_q.size()), 25);
    if (la_q.size() == 25) begin
      for (int i = 0; i < 20; i++) begin
        chk("bp_fill_addr", 32'(la_q[i]), 32'h400 + 32'(i));
        chk("bp_fill_data", 32'(ld_q[i]), 'h5A);
      end
      for (int i = 0; i < 5; i++) begin
        chk("bp_q_addr", 32'(la_q[20+i]), 32'h500 + 32'(i));
        chk("bp_q_data", 32'(ld_q[20+i]), 32'hC0 + 32'(i));
      end
    end

    // Zero-length fill: one cycle in FILL, no write
    phase_run = 1'b0;
    fetch_phase = 4'd5;
    cyc();
    la_q.delete(); ld_q.delete();
    cmd(FL, 13'h0010, 8'hEE, 13'd0);
    cyc();
    host_valid = 1'b0;
    chk("z_busy", 32'(busy), 1);
    chk("z_we", 32'(vram_we), 0);
    cyc();
    chk("z_busy_fall", 32'(busy), 0);
    chk("z_we2", 32'(vram_we), 0);
    cyc();
    chk("z_nowrites", 32'(la_q.size()), 0);

    // Mode word 0x1D = 1_110_1: css=1, gm=110, ag=1
    cmd(MD, 13'h0, 8'h1D, 13'd0); #1;
    chk("md_ready", 32'(host_ready), 1);
    cyc();
    host_valid = 1'b0;
    chk("md_hold_gm", 32'(gm), 0);
    cyc();
    chk("md_hold_ag", 32'(ag), 0);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("md_ag", 32'(ag), 1);
    chk("md_gm", 32'(gm), 'b110);
    chk("md_css", 32'(css), 1);
    // Pending 0x02 (gm=001); then 0x11 (css=1, ag=1) arrives with frame_start
    cmd(MD, 13'h0, 8'h02, 13'd0);
    cyc();
    cmd(MD, 13'h0, 8'h11, 13'd0);
    frame_start = 1'b1;
    cyc();
    host_valid = 1'b0;
    frame_start = 1'b0;
    chk("md_old_ag", 32'(ag), 0);
    chk("md_old_gm", 32'(gm), 'b001);
    chk("md_old_css", 32'(css), 0);
    cyc();
    chk("md_wait_gm", 32'(gm), 'b001);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("md_new_ag", 32'(ag), 1);
    chk("md_new_gm", 32'(gm), 0);
    chk("md_new_css", 32'(css), 1);

    // Reset in the middle of a 100-byte fill
    cmd(FL, 13'h0800, 8'h77, 13'd100);
    cyc();
    host_valid = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("mr_pre_we", 32'(vram_we), 1);
    chk("mr_pre_busy", 32'(busy), 1);
    reset = 1'b1; #1;
    chk("mr_we", 32'(vram_we), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ag", 32'(ag), 0);
    chk("mr_gm", 32'(gm), 0);
    chk("mr_css", 32'(css), 0);
    cyc();
    reset = 1'b0;
    cyc();
    cmd(WR, 13'h0123, 8'h9C, 13'd0); #1;
    chk("mr_wr_ready", 32'(host_ready), 1);
    cyc();
    host_valid = 1'b0;
    chk("mr_wr_we", 32'(vram_we), 1);
    chk("mr_wr_addr", 32'(vram_waddr), 'h123);
    chk("mr_wr_data", 32'(vram_wdata), 'h9C);
    cyc();
    chk("mr_no_fill", 32'(vram_we), 0);
    chk("mr_idle", 32'(busy), 0);

    chk("slot_violations", 32'(phase_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
